// File: rtl/acc_bank_drain_ctrl_pkg.sv
// Shared types for the accumulator bank drain controller: data word width and FSM states.
// The accumulator word width is 32 bits.
package acc_bank_drain_ctrl_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/acc_bank_drain_ctrl_if.sv
// Row stream from the drain controller to the PPU.
// Handshake: a beat transfers at a posedge where m_valid and m_ready are both 1; while
// m_valid=1 and m_ready=0 the master holds m_data, m_row and m_last stable.
interface acc_bank_drain_ctrl_if #(
    parameter int NUM_COLS   = 16,
    parameter int DEPTH_LOG2 = 8
);
    import acc_bank_drain_ctrl_pkg::*;

    logic                      m_valid;
    logic                      m_ready;
    logic [NUM_COLS*ACC_W-1:0] m_data;
    logic [DEPTH_LOG2-1:0]     m_row;
    logic                      m_last;

    modport master (
        output m_valid, m_data, m_row, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_row, m_last,
        output m_ready
    );
endinterface

// File: rtl/acc_bank_drain_ctrl_out_slice.sv
// drain_out_slice: one-entry valid/ready output register holding a row beat.
// can_load is high when the slot is empty or is being emptied this cycle.
module drain_out_slice
    import acc_bank_drain_ctrl_pkg::*;
#(
    parameter int NUM_COLS   = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [NUM_COLS*ACC_W-1:0] ld_data,
    input  logic [DEPTH_LOG2-1:0]     ld_row,
    input  logic                      ld_last,
    input  logic                      out_ready,
    output logic                      can_load,
    output logic                      out_valid,
    output logic [NUM_COLS*ACC_W-1:0] out_data,
    output logic [DEPTH_LOG2-1:0]     out_row,
    output logic                      out_last
);
    localparam int DW = NUM_COLS * ACC_W;

    logic                  valid_q, valid_d;
    logic [DW-1:0]         data_q,  data_d;
    logic [DEPTH_LOG2-1:0] row_q,   row_d;
    logic                  last_q,  last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        row_d   = row_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = ld_data;
            row_d   = ld_row;
            last_d  = ld_last;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            row_q   <= row_d;
            last_q  <= last_d;
        end
    end

    assign can_load  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_last  = last_q;
endmodule

// File: rtl/acc_bank_drain_ctrl.sv
// Drains rows 0..num_rows-1 of the column-bank accumulator array into the PPU stream.
// Optional build macro DRAIN_CLEAR_EN: strobe bank_clr_wr_en on each capture to zero the row.
module acc_bank_drain_ctrl
    import acc_bank_drain_ctrl_pkg::*;
#(
    parameter int NUM_COLS   = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DEPTH_LOG2:0]       num_rows,
    output logic                      busy,
    output logic                      done,
    output logic [DEPTH_LOG2-1:0]     bank_addr,
    input  logic [NUM_COLS*ACC_W-1:0] bank_rd_data,
    output logic                      bank_clr_wr_en,
    acc_bank_drain_ctrl_if.master     m_if,
    output drain_state_e              dbg_state
);
    localparam int unsigned MAX_ROWS_I = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] MAX_ROWS = MAX_ROWS_I[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] ONE_ROW  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    drain_state_e          state_q, state_d;
    logic [DEPTH_LOG2:0]   rows_q,  rows_d;
    logic [DEPTH_LOG2-1:0] addr_q,  addr_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    logic                  load;
    logic                  can_load;
    logic                  is_last;
    logic                  out_valid;
    logic [DEPTH_LOG2:0]   rows_clamped;

    assign rows_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
    assign is_last      = ({1'b0, addr_q} == (rows_q - ONE_ROW));

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The done-pulse cycle is still closing the previous drain, so start waits one more cycle.
                if (start && !done_q) begin
                    rows_d  = rows_clamped;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = (rows_clamped == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (can_load) begin
                    load = 1'b1;
                    // Hold the address on the final row so it never wraps to 0 at full depth.
                    if (is_last) state_d = ST_FLUSH;
                    else         addr_d  = addr_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (out_valid && m_if.m_ready) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rows_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    drain_out_slice #(
        .NUM_COLS  (NUM_COLS),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_out_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .ld_data  (bank_rd_data),
        .ld_row   (addr_q),
        .ld_last  (is_last),
        .out_ready(m_if.m_ready),
        .can_load (can_load),
        .out_valid(out_valid),
        .out_data (m_if.m_data),
        .out_row  (m_if.m_row),
        .out_last (m_if.m_last)
    );

`ifdef DRAIN_CLEAR_EN
    // The bank wrapper applies the clear after the read path, so the capture sees the old row.
    assign bank_clr_wr_en = load;
`else
    assign bank_clr_wr_en = 1'b0;
`endif

    assign m_if.m_valid = out_valid;
    assign busy         = busy_q;
    assign done         = done_q;
    assign bank_addr    = addr_q;
    assign dbg_state    = state_q;
endmodule
